// File: rtl/seg7_scan_if.sv
// Bus between a display-value producer and the multiplexed 7-segment scan controller.
// The master loads values into the controller; the slave drives the digit/segment side.
interface seg7_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  lzb_en;
    logic [3:0]            bcd_out;
    logic                  dp_n;
    logic [DIGITS-1:0]     dig_n;
    logic                  frame_start;
    logic                  pending;

    modport master (
        output load, bcd_in, dp_in, lzb_en,
        input  bcd_out, dp_n, dig_n, frame_start, pending
    );

    modport slave (
        input  load, bcd_in, dp_in, lzb_en,
        output bcd_out, dp_n, dig_n, frame_start, pending
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with per-slot anti-ghost blanking,
// leading-zero blanking and tear-free, frame-aligned commit of shadowed display values.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [IDX_W-1:0]   idx, nxt_idx;
    logic [BCD_W-1:0]   act_bcd, nxt_act_bcd, shd_bcd;
    logic [DIGITS-1:0]  act_dp, nxt_act_dp, shd_dp;
    logic               act_lzb, nxt_act_lzb, shd_lzb;
    logic               slot_wrap, commit;

    logic [DIGITS-1:0]  lz_blank;
    logic               lz_run;
    logic [3:0]         nxt_digit;
    logic               digit_bad;
    logic [3:0]         nxt_bcd_out;
    logic               nxt_dp_n;
    logic [DIGITS-1:0]  nxt_dig_n;

    // Slot/digit sequencing and frame commit; a load in the commit cycle bypasses the shadow.
    always_comb begin
        slot_wrap   = (cnt == CNT_LAST);
        commit      = slot_wrap && (idx == IDX_LAST);
        nxt_cnt     = slot_wrap ? '0 : cnt + CNT_W'(1);
        nxt_idx     = idx;
        nxt_state   = state;
        nxt_act_bcd = act_bcd;
        nxt_act_dp  = act_dp;
        nxt_act_lzb = act_lzb;
        if (slot_wrap) begin
            nxt_idx = commit ? '0 : idx + IDX_W'(1);
        end
        if (slot_wrap) begin
            nxt_state = S_BLANK;
        end else if (cnt == BLANK_LAST) begin
            nxt_state = S_SHOW;
        end
        if (commit) begin
            if (bus.load) begin
                nxt_act_bcd = bus.bcd_in;
                nxt_act_dp  = bus.dp_in;
                nxt_act_lzb = bus.lzb_en;
            end else begin
                nxt_act_bcd = shd_bcd;
                nxt_act_dp  = shd_dp;
                nxt_act_lzb = shd_lzb;
            end
        end
    end

    // A digit is a leading zero while it and every digit above it are 0 with no dp.
    always_comb begin
        lz_run   = nxt_act_lzb;
        lz_blank = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lz_run      = lz_run && (nxt_act_bcd[4*i +: 4] == 4'd0) && !nxt_act_dp[i];
            lz_blank[i] = lz_run;
        end
    end

    // Outputs are derived from next state so the registered pins line up with the state.
    always_comb begin
        nxt_digit   = nxt_act_bcd[{nxt_idx, 2'b00} +: 4];
        digit_bad   = (nxt_digit > 4'd9);
        nxt_bcd_out = digit_bad ? 4'hF : nxt_digit;
        nxt_dig_n   = '1;
        nxt_dp_n    = 1'b1;
        if ((nxt_state == S_SHOW) && !digit_bad && !lz_blank[nxt_idx]) begin
            nxt_dig_n[nxt_idx] = 1'b0;
            nxt_dp_n           = ~nxt_act_dp[nxt_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_BLANK;
            cnt             <= '0;
            idx             <= '0;
            act_bcd         <= '0;
            act_dp          <= '0;
            act_lzb         <= 1'b0;
            shd_bcd         <= '0;
            shd_dp          <= '0;
            shd_lzb         <= 1'b0;
            bus.pending     <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.bcd_out     <= 4'd0;
            bus.dp_n        <= 1'b1;
            bus.dig_n       <= '1;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            idx             <= nxt_idx;
            act_bcd         <= nxt_act_bcd;
            act_dp          <= nxt_act_dp;
            act_lzb         <= nxt_act_lzb;
            if (bus.load) begin
                shd_bcd <= bus.bcd_in;
                shd_dp  <= bus.dp_in;
                shd_lzb <= bus.lzb_en;
            end
            if (commit) begin
                bus.pending <= 1'b0;
            end else if (bus.load) begin
                bus.pending <= 1'b1;
            end
            bus.frame_start <= commit;
            bus.bcd_out     <= nxt_bcd_out;
            bus.dp_n        <= nxt_dp_n;
            bus.dig_n       <= nxt_dig_n;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Frames are checked cycle by cycle against hand-computed per-digit expectations.
module tb_seg7_scan_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seg7_scan_if #(.DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .DIGITS(4),
        .SCAN_DIV(8),
        .BLANK_CYC(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_on;
        logic [3:0]  exp_dpn;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk one full frame starting at its digit-0 / count-0 cycle.
    task automatic check_frame(input logic [15:0] eb, input logic [3:0] on, input logic [3:0] dpn);
        logic [3:0] digit;
        logic [3:0] exp_dig;
        logic       exp_dp;
        for (int d = 0; d < 4; d++) begin
            digit = eb[4*d +: 4];
            for (int c = 0; c < 8; c++) begin
                if (c < 2 || !on[d]) begin
                    exp_dig = 4'hF;
                    exp_dp  = 1'b1;
                end else begin
                    exp_dig = ~(4'b0001 << d);
                    exp_dp  = dpn[d];
                end
                chk($sformatf("dig_n d%0d c%0d", d, c), 32'(bus.dig_n), 32'(exp_dig));
                chk($sformatf("bcd_out d%0d c%0d", d, c), 32'(bus.bcd_out), 32'(digit));
                chk($sformatf("dp_n d%0d c%0d", d, c), 32'(bus.dp_n), 32'(exp_dp));
                chk($sformatf("frame_start d%0d c%0d", d, c), 32'(bus.frame_start),
                    32'(d == 0 && c == 0));
                chk($sformatf("pending d%0d c%0d", d, c), 32'(bus.pending), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    // Bounded wait for frame_start; returns the number of cycles waited.
    task automatic wait_frame(output int n);
        n = 0;
        while (!bus.frame_start && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drive_load(input logic [15:0] b, input logic [3:0] dp, input logic lzb);
        bus.load   = 1'b1;
        bus.bcd_in = b;
        bus.dp_in  = dp;
        bus.lzb_en = lzb;
    endtask

    // Load at count 0 of digit 0, expect commit exactly one frame later, then check it.
    task automatic do_vector(input vec_t v, input int k);
        int n;
        drive_load(v.bcd, v.dp, v.lzb);
        @(negedge clk);
        bus.load = 1'b0;
        chk($sformatf("vec%0d pending after load", k), 32'(bus.pending), 32'd1);
        wait_frame(n);
        chk($sformatf("vec%0d commit latency", k), 32'(n), 32'd31);
        check_frame(v.exp_bcd, v.exp_on, v.exp_dpn);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b1111, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, 16'h0070, 4'b0011, 4'b1111};
        vecs[2] = '{16'h0070, 4'b0100, 1'b1, 16'h0070, 4'b0111, 4'b1011};
        vecs[3] = '{16'h9A05, 4'b0000, 1'b0, 16'h9F05, 4'b1011, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0001, 4'b1111};
        vecs[5] = '{16'h0000, 4'b1111, 1'b0, 16'h0000, 4'b1111, 4'b0000};
        vecs[6] = '{16'hC0B0, 4'b0010, 1'b1, 16'hF0F0, 4'b0101, 4'b1111};
        vecs[7] = '{16'h0305, 4'b0001, 1'b1, 16'h0305, 4'b0111, 4'b1110};

        rst_n      = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        bus.lzb_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dig_n", 32'(bus.dig_n), 32'hF);
        chk("reset dp_n", 32'(bus.dp_n), 32'd1);
        chk("reset bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("reset frame_start", 32'(bus.frame_start), 32'd0);
        chk("reset pending", 32'(bus.pending), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) do_vector(vecs[k], k);

        // Two loads mid-frame: current frame untouched, last load wins at next frame.
        repeat (16) @(negedge clk);
        drive_load(16'h1111, 4'b0000, 1'b0);
        @(negedge clk);
        bus.bcd_in = 16'h2222;
        chk("double load pending c17", 32'(bus.pending), 32'd1);
        @(negedge clk);
        bus.load = 1'b0;
        chk("double load pending c18", 32'(bus.pending), 32'd1);
        chk("no tear dig_n d2", 32'(bus.dig_n), 32'b1011);
        chk("no tear bcd d2", 32'(bus.bcd_out), 32'd3);
        repeat (8) @(negedge clk);
        chk("no tear dig_n d3", 32'(bus.dig_n), 32'hF);
        chk("no tear bcd d3", 32'(bus.bcd_out), 32'd0);
        chk("double load pending d3", 32'(bus.pending), 32'd1);
        wait_frame(n);
        chk("double load latency", 32'(n), 32'd6);
        check_frame(16'h2222, 4'b1111, 4'b1111);

        // Load landing exactly on the commit cycle.
        repeat (31) @(negedge clk);
        chk("pre-commit pending", 32'(bus.pending), 32'd0);
        drive_load(16'h8765, 4'b1010, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        chk("commit-cycle frame_start", 32'(bus.frame_start), 32'd1);
        chk("commit-cycle pending", 32'(bus.pending), 32'd0);
        check_frame(16'h8765, 4'b1111, 4'b0101);

        // Asynchronous reset in the SHOW phase of digit 2 with a load pending.
        repeat (18) @(negedge clk);
        drive_load(16'h1111, 4'b0000, 1'b0);
        @(negedge clk);
        bus.load = 1'b0;
        chk("pre-reset pending", 32'(bus.pending), 32'd1);
        chk("pre-reset dig_n", 32'(bus.dig_n), 32'b1011);
        chk("pre-reset bcd", 32'(bus.bcd_out), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset dig_n", 32'(bus.dig_n), 32'hF);
        chk("async reset dp_n", 32'(bus.dp_n), 32'd1);
        chk("async reset bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("async reset frame_start", 32'(bus.frame_start), 32'd0);
        chk("async reset pending", 32'(bus.pending), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("post-reset blank dig_n", 32'(bus.dig_n), 32'hF);
        repeat (2) @(negedge clk);
        chk("post-reset digit0 dig_n", 32'(bus.dig_n), 32'b1110);
        chk("post-reset digit0 bcd", 32'(bus.bcd_out), 32'd0);
        chk("post-reset digit0 dp_n", 32'(bus.dp_n), 32'd1);
        wait_frame(n);
        chk("post-reset first frame_start", 32'(n), 32'd30);
        check_frame(16'h0000, 4'b1111, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
